// File: rtl/muldiv_pkg.sv
// ---- muldiv_pkg : HI/LO unit op codes, FSM states and decode helper -- rev 1.0 ----
`default_nettype none

package muldiv_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIV_RUN = 3'd1,
    ST_MUL_RUN = 3'd2,
    ST_DONE    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  function automatic logic is_longop(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_unit_if.sv
// ---- hilo_unit_if : start/clear handshake and operand/result bus to the iterative divider -- rev 1.0 ----
`default_nettype none

interface hilo_unit_if;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_signed;
  logic        div_start;
  logic        div_clr;
  logic [63:0] div_result;
  logic        div_busy;

  modport master (
    output div_a, div_b, div_signed, div_start, div_clr,
    input  div_result, div_busy
  );

  modport slave (
    input  div_a, div_b, div_signed, div_start, div_clr,
    output div_result, div_busy
  );
endinterface

`default_nettype wire

// File: rtl/mul_pipe.sv
// ---- mul_pipe : 33x33 signed multiplier, operand regs + (MUL_CYCLES-1) product stages -- rev 1.0 ----
`default_nettype none

module mul_pipe #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        out_valid_o,
  output logic [63:0] product_o
);

  logic [32:0] a_q;
  logic [32:0] b_q;
  logic        v_q;
  logic [63:0] w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid_i & ~flush_i;
      if (in_valid_i) begin
        a_q <= {signed_i & a_i[31], a_i};
        b_q <= {signed_i & b_i[31], b_i};
      end
    end
  end

  // Low 64 bits of a product are the same for signed and unsigned operands once sign-extended.
  assign w_prod = {{31{a_q[32]}}, a_q} * {{31{b_q[32]}}, b_q};

  generate
    if (MUL_CYCLES > 1) begin : g_pipe
      localparam int STAGES = MUL_CYCLES - 1;
      logic [63:0]       prod_q [STAGES];
      logic [STAGES-1:0] vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < STAGES; i++) prod_q[i] <= '0;
        end else begin
          vld_q[0]  <= v_q & ~flush_i;
          prod_q[0] <= w_prod;
          for (int i = 1; i < STAGES; i++) begin
            vld_q[i]  <= vld_q[i-1] & ~flush_i;
            prod_q[i] <= prod_q[i-1];
          end
        end
      end

      assign out_valid_o = vld_q[STAGES-1];
      assign product_o   = prod_q[STAGES-1];
    end else begin : g_comb
      assign out_valid_o = v_q;
      assign product_o   = w_prod;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/hilo_unit.sv
// ---- hilo_unit : EXE-stage HI/LO controller, sequences mul/div and stalls the pipe -- rev 1.0 ----
`default_nettype none

module hilo_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [31:0]       rs_i,
  input  logic [31:0]       rt_i,
  input  logic              ex_stall_i,
  input  logic              flush_i,
  hilo_unit_if.master       div_if,
  output logic              stall_req_o,
  output logic [31:0]       rd_val_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o
);

  localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      div_a_q, div_a_d, div_b_q, div_b_d;
  logic             div_signed_q, div_signed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  op_e              w_op;
  logic             w_stall;
  logic             w_mul_start;
  logic             w_mul_valid;
  logic             w_mul_done;
  logic [63:0]      w_mul_product;

  // Invalid slots and unknown codes decode to OP_NONE.
  assign w_op = (valid_i && (op_i <= OP_W'(OP_MFLO))) ? op_e'(op_i) : OP_NONE;

  mul_pipe #(.MUL_CYCLES(MUL_CYCLES)) u_mul_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (w_mul_start),
    .signed_i    (w_op == OP_MULT),
    .a_i         (rs_i),
    .b_i         (rt_i),
    .out_valid_o (w_mul_valid),
    .product_o   (w_mul_product)
  );

  assign w_mul_done = (cnt_q == CNT_LAST) && w_mul_valid;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_signed_d = div_signed_q;
    cnt_d        = cnt_q;
    w_stall      = 1'b0;
    w_mul_start  = 1'b0;

    if (flush_i) begin
      state_d = ST_DRAIN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          case (w_op)
            OP_DIV, OP_DIVU: begin
              div_a_d      = rs_i;
              div_b_d      = rt_i;
              div_signed_d = (w_op == OP_DIV);
              w_stall      = 1'b1;
              state_d      = ST_DIV_RUN;
            end
            OP_MULT, OP_MULTU: begin
              w_mul_start = 1'b1;
              w_stall     = 1'b1;
              cnt_d       = '0;
              state_d     = ST_MUL_RUN;
            end
            OP_MTHI: if (!ex_stall_i) hi_d = rs_i;
            OP_MTLO: if (!ex_stall_i) lo_d = rs_i;
            default: ;
          endcase
        end
        ST_DIV_RUN: begin
          if (div_if.div_busy) begin
            w_stall = 1'b1;
          end else begin
            {hi_d, lo_d} = div_if.div_result;
            // DONE only guards an instruction that stays in EXE; otherwise the next one is live.
            state_d = ex_stall_i ? ST_DONE : ST_IDLE;
          end
        end
        ST_MUL_RUN: begin
          if (w_mul_done) begin
            {hi_d, lo_d} = w_mul_product;
            state_d      = ex_stall_i ? ST_DONE : ST_IDLE;
          end else begin
            w_stall = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (!ex_stall_i) state_d = ST_IDLE;
        end
        ST_DRAIN: begin
          // Divider needs this cycle to leave its end state before a new start.
          w_stall = is_longop(w_op);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_signed_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_signed_q <= div_signed_d;
      cnt_q        <= cnt_d;
    end
  end

  assign div_if.div_a      = div_a_q;
  assign div_if.div_b      = div_b_q;
  assign div_if.div_signed = div_signed_q;
  assign div_if.div_start  = (state_q == ST_DIV_RUN) & ~flush_i;
  assign div_if.div_clr    = flush_i | (state_q == ST_DRAIN);

  assign stall_req_o = w_stall;
  assign rd_val_o    = (w_op == OP_MFHI) ? hi_q :
                       (w_op == OP_MFLO) ? lo_q : 32'd0;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_unit.sv
// ---- tb_hilo_unit : directed scoreboard bench for hilo_unit with a behavioural divider -- rev 1.0 ----
`default_nettype none

module tb_hilo_unit;
  import muldiv_pkg::*;

  localparam int STALL_LIMIT = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        ex_stall, flush;
  logic        stall_req_o;
  logic [31:0] rd_val_o, hi_o, lo_o;

  int passed = 0;
  int total  = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  hilo_unit_if dif ();

  hilo_unit #(.MUL_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid),
    .op_i        (op),
    .rs_i        (rs),
    .rt_i        (rt),
    .ex_stall_i  (ex_stall),
    .flush_i     (flush),
    .div_if      (dif),
    .stall_req_o (stall_req_o),
    .rd_val_o    (rd_val_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  // Iterative divider: FREE -> ON (33 cycles) or ZERO (1 cycle) -> END; busy except in END.
  typedef enum logic [1:0] {D_FREE, D_ZERO, D_ON, D_END} dstate_e;
  dstate_e     dst;
  int          dcnt;
  logic [63:0] dres;

  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst  <= D_FREE;
      dcnt <= 0;
      dres <= '0;
    end else if (dif.div_clr) begin
      dst <= D_FREE;
    end else begin
      case (dst)
        D_FREE: if (dif.div_start) begin
          dres <= div_ref(dif.div_a, dif.div_b, dif.div_signed);
          dcnt <= 0;
          dst  <= (dif.div_b == 32'd0) ? D_ZERO : D_ON;
        end
        D_ZERO: dst <= D_END;
        D_ON:   if (dcnt == 32) dst <= D_END; else dcnt <= dcnt + 1;
        D_END:  if (!dif.div_start) dst <= D_FREE;
        default: dst <= D_FREE;
      endcase
    end
  end

  assign dif.div_busy   = (dst != D_END);
  assign dif.div_result = dres;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Counts stall cycles from the current negedge, then pops and checks the write at completion.
  task automatic finish_op(input string tag, input int exp_stalls);
    int n = 0;
    logic [63:0] e;
    while (stall_req_o === 1'b1 && n < STALL_LIMIT) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_stalls"}, 64'(n), 64'(exp_stalls));
    @(posedge clk); #1;
    valid = 1'b0;
    op    = OP_NONE;
    e = sb.pop_front();
    chk({tag, "_hilo"}, {hi_o, lo_o}, e);
  endtask

  task automatic long_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stalls,
                         input logic [31:0] ehi, input logic [31:0] elo);
    sb.push_back({ehi, elo});
    @(posedge clk); #1;
    valid = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(negedge clk);
    finish_op(tag, exp_stalls);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; valid = 1'b0; op = OP_NONE; rs = '0; rt = '0;
    ex_stall = 1'b0; flush = 1'b0;

    #12;
    chk("rst_hi",      64'(hi_o), 64'd0);
    chk("rst_lo",      64'(lo_o), 64'd0);
    chk("rst_stall",   64'(stall_req_o), 64'd0);
    chk("rst_start",   64'(dif.div_start), 64'd0);
    chk("rst_clr",     64'(dif.div_clr), 64'd0);
    chk("rst_div_ab",  {dif.div_a, dif.div_b}, 64'd0);
    chk("rst_div_sgn", 64'(dif.div_signed), 64'd0);
    #10 rst_n = 1'b1;

    long_op("div_100_7",   OP_DIV,   32'd100,       32'd7, 35, 32'd2,        32'd14);
    long_op("divu_max_2",  OP_DIVU,  32'hFFFFFFFF,  32'd2, 35, 32'd1,        32'h7FFFFFFF);
    long_op("div_m7_2",    OP_DIV,   32'hFFFFFFF9,  32'd2, 35, 32'hFFFFFFFF, 32'hFFFFFFFD);
    long_op("div_by_zero", OP_DIV,   32'd55,        32'd0,  3, 32'd0,        32'd0);
    long_op("mult_m1_2",   OP_MULT,  32'hFFFFFFFF,  32'd2,  2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    long_op("multu_max_2", OP_MULTU, 32'hFFFFFFFF,  32'd2,  2, 32'd1,        32'hFFFFFFFE);

    // MT*/MF* and decode of non-HI/LO codes
    @(posedge clk); #1; valid = 1'b1; op = OP_MTHI; rs = 32'd5;
    @(posedge clk); #1; op = OP_MFHI; rs = 32'd0;
    @(negedge clk);
    chk("mfhi_after_mthi", 64'(rd_val_o), 64'd5);
    chk("mfhi_no_stall",   64'(stall_req_o), 64'd0);
    @(posedge clk); #1; op = OP_MTLO; rs = 32'h1234; ex_stall = 1'b1;
    @(posedge clk); #1; ex_stall = 1'b0; op = OP_MFLO;
    @(negedge clk);
    chk("mtlo_held_rdval", 64'(rd_val_o), 64'hFFFFFFFE);
    chk("mtlo_held_lo",    64'(lo_o), 64'hFFFFFFFE);
    @(posedge clk); #1; op = OP_MTLO; rs = 32'h1234;
    @(posedge clk); #1; op = 4'hF;
    @(negedge clk);
    chk("mtlo_lo",          64'(lo_o), 64'h1234);
    chk("unknown_op_rdval", 64'(rd_val_o), 64'd0);
    chk("unknown_op_stall", 64'(stall_req_o), 64'd0);
    @(posedge clk); #1; valid = 1'b0; op = OP_NONE;

    // Completion while EXE is held by another source for 3 cycles
    sb.push_back({32'd0, 32'd100});
    @(posedge clk); #1; valid = 1'b1; op = OP_DIVU; rs = 32'd1000; rt = 32'd10;
    @(negedge clk);
    n = 0;
    while (stall_req_o === 1'b1 && n < STALL_LIMIT) begin
      n++;
      @(negedge clk);
    end
    chk("hold_stalls", 64'(n), 64'd35);
    ex_stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 3) ex_stall = 1'b0;
      @(negedge clk);
      chk($sformatf("hold_start_c%0d", k), 64'(dif.div_start), 64'd0);
      chk($sformatf("hold_stall_c%0d", k), 64'(stall_req_o), 64'd0);
    end
    @(posedge clk); #1; valid = 1'b0; op = OP_NONE;
    chk("hold_hilo", {hi_o, lo_o}, sb.pop_front());
    @(negedge clk);
    chk("hold_no_reissue", 64'(dif.div_start), 64'd0);

    // Flush in cycle 10 of a DIV, then a DIV presented during DRAIN
    @(posedge clk); #1; valid = 1'b1; op = OP_DIV; rs = 32'd100; rt = 32'd7;
    repeat (10) @(posedge clk);
    #1; flush = 1'b1;
    @(negedge clk);
    chk("flush_clr",   64'(dif.div_clr), 64'd1);
    chk("flush_start", 64'(dif.div_start), 64'd0);
    chk("flush_stall", 64'(stall_req_o), 64'd0);
    @(posedge clk); #1; flush = 1'b0;
    sb.push_back({32'd2, 32'd14});
    @(negedge clk);
    chk("drain_clr",   64'(dif.div_clr), 64'd1);
    chk("drain_start", 64'(dif.div_start), 64'd0);
    chk("drain_hilo",  {hi_o, lo_o}, {32'd0, 32'd100});
    finish_op("drain_div", 36);
    long_op("b2b_div", OP_DIV, 32'hFFFFFFF9, 32'd2, 35, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // Asynchronous reset in the middle of a DIVU
    @(posedge clk); #1; valid = 1'b1; op = OP_DIVU; rs = 32'd50; rt = 32'd5;
    repeat (5) @(negedge clk);
    chk("pre_rst_stall", 64'(stall_req_o), 64'd1);
    rst_n = 1'b0; valid = 1'b0; op = OP_NONE;
    #1;
    chk("mid_rst_hilo",  {hi_o, lo_o}, 64'd0);
    chk("mid_rst_start", 64'(dif.div_start), 64'd0);
    chk("mid_rst_stall", 64'(stall_req_o), 64'd0);
    chk("mid_rst_div_a", 64'(dif.div_a), 64'd0);
    #2 rst_n = 1'b1;
    long_op("post_rst_multu", OP_MULTU, 32'd3,  32'd5, 2,  32'd0, 32'd15);
    long_op("post_rst_div",   OP_DIV,   32'd20, 32'd6, 35, 32'd2, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
